// File: rtl/quad_step_decoder.sv
// Quadrature front end: sync, glitch filter, Gray decode, divide-by-DIV step strobes, index load.
// Optional saturating error counter on output err_count when QDEC_ERR_CNT_EN is defined.
module quad_step_decoder #(
  parameter int         FILTER_LEN = 4,
  parameter int         DIV        = 4,
  parameter logic [3:0] LOAD_VALUE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       idx_in,
  output logic       enable,
  output logic       upordown,
  output logic       load,
  output logic [3:0] num2load,
  output logic       err
`ifdef QDEC_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0]        FL_M1 = 4'(FILTER_LEN - 1);
  localparam logic signed [3:0] DIV_P = 4'(DIV);
  localparam logic signed [3:0] DIV_N = 4'(-DIV);

  logic              a_s1, a_s2, b_s1, b_s2, idx_s1, idx_s2, idx_d;
  logic [3:0]        a_cnt, b_cnt;
  logic              a_f, b_f;
  logic [1:0]        prev;
  logic signed [3:0] acc;

  logic [1:0]        cur;
  logic              fwd, rev, ill, idx_rise, hit_up, hit_dn;
  logic signed [3:0] acc_step;

  // Next state when stepping forward through 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   fwd_of = 2'b01;
      2'b01:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b10;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  assign num2load = LOAD_VALUE;

  always_comb begin
    cur      = {a_f, b_f};
    fwd      = (cur == fwd_of(prev));
    rev      = (prev == fwd_of(cur));
    ill      = ((cur ^ prev) == 2'b11);
    idx_rise = idx_s2 & ~idx_d;
    acc_step = acc;
    if (fwd)
      acc_step = acc + 4'sd1;
    else if (rev)
      acc_step = acc - 4'sd1;
    hit_up   = fwd && (acc_step == DIV_P);
    hit_dn   = rev && (acc_step == DIV_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1     <= 1'b0;
      a_s2     <= 1'b0;
      b_s1     <= 1'b0;
      b_s2     <= 1'b0;
      idx_s1   <= 1'b0;
      idx_s2   <= 1'b0;
      idx_d    <= 1'b0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      a_f      <= 1'b0;
      b_f      <= 1'b0;
      prev     <= 2'b00;
      acc      <= '0;
      enable   <= 1'b0;
      upordown <= 1'b1;
      load     <= 1'b0;
      err      <= 1'b0;
    end else begin
      a_s1   <= a_in;
      a_s2   <= a_s1;
      b_s1   <= b_in;
      b_s2   <= b_s1;
      idx_s1 <= idx_in;
      idx_s2 <= idx_s1;
      idx_d  <= idx_s2;

      // A filtered channel only follows the synced input after FILTER_LEN disagreeing clocks.
      if (a_s2 == a_f)
        a_cnt <= '0;
      else if (a_cnt == FL_M1) begin
        a_f   <= a_s2;
        a_cnt <= '0;
      end else
        a_cnt <= a_cnt + 4'd1;

      if (b_s2 == b_f)
        b_cnt <= '0;
      else if (b_cnt == FL_M1) begin
        b_f   <= b_s2;
        b_cnt <= '0;
      end else
        b_cnt <= b_cnt + 4'd1;

      prev   <= cur;
      err    <= ill;
      load   <= idx_rise;
      enable <= 1'b0;

      // Index wins over a completing step: the counter is being reloaded anyway.
      if (idx_rise || ill)
        acc <= '0;
      else if (hit_up || hit_dn) begin
        acc      <= '0;
        enable   <= 1'b1;
        upordown <= hit_up;
      end else
        acc <= acc_step;
    end
  end

`ifdef QDEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: reference model pushes expected strobe events, a monitor pops and compares them.
module tb_quad_step_decoder;

  localparam int         FL   = 4;
  localparam int         DIVP = 4;
  localparam logic [3:0] LV   = 4'd9;

  logic       clk;
  logic       rst;
  logic       a_in, b_in, idx_in;
  logic       enable, upordown, load, err;
  logic [3:0] num2load;
`ifdef QDEC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  quad_step_decoder #(.FILTER_LEN(FL), .DIV(DIVP), .LOAD_VALUE(LV)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .idx_in   (idx_in),
    .enable   (enable),
    .upordown (upordown),
    .load     (load),
    .num2load (num2load),
    .err      (err)
`ifdef QDEC_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  typedef struct {
    int   cyc;
    logic en;
    logic ud;
    logic ld;
    logic er;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ev_cnt = 0;
  logic [1:0] mdl_prev;
  int         mdl_acc;
  logic       mdl_ud;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Scoreboard consumer: every strobe the DUT raises must match the oldest expected event.
  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (enable || load || err) begin
        ev_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event cyc=%0d got en=%b ud=%b ld=%b err=%b, required none",
                   cyc, enable, upordown, load, err);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || enable !== e.en || upordown !== e.ud || load !== e.ld ||
              err !== e.er || (load && num2load !== LV)) begin
            n_err++;
            $display("FAIL event got cyc=%0d en=%b ud=%b ld=%b err=%b n2l=%0d, required cyc=%0d en=%b ud=%b ld=%b err=%b n2l=%0d",
                     cyc, enable, upordown, load, err, num2load, e.cyc, e.en, e.ud, e.ld, e.er, LV);
          end
        end
      end
    end
  endtask

  // Drives a new {a,b} state, predicts its effect, then holds it.
  task automatic drive_ab(input logic [1:0] s, input int hold, input bit with_idx);
    int d;
    int k;
    @(posedge clk);
    #1;
    a_in = s[1];
    b_in = s[0];
    k = cyc;
    d = (pos(s) - pos(mdl_prev) + 4) % 4;
    mdl_prev = s;
    if (with_idx) begin
      mdl_acc = 0;
      exp_q.push_back('{k + 7, 1'b0, mdl_ud, 1'b1, (d == 2)});
    end else if (d == 2) begin
      mdl_acc = 0;
      exp_q.push_back('{k + 7, 1'b0, mdl_ud, 1'b0, 1'b1});
    end else begin
      if (d == 1) mdl_acc++;
      if (d == 3) mdl_acc--;
      if (mdl_acc == DIVP || mdl_acc == -DIVP) begin
        mdl_ud  = (mdl_acc > 0);
        mdl_acc = 0;
        exp_q.push_back('{k + 7, 1'b1, mdl_ud, 1'b0, 1'b0});
      end
    end
    if (with_idx) begin
      repeat (4) @(posedge clk);
      #1 idx_in = 1'b1;
      repeat (hold - 5) @(posedge clk);
    end else
      repeat (hold - 1) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    idx_in = 1'b0;
    mdl_prev = 2'b00;
    mdl_acc = 0;
    mdl_ud = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b required 0", enable); end
    n_chk++;
    if (load !== 1'b0) begin n_err++; $display("FAIL reset_load got %b required 0", load); end
    n_chk++;
    if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b required 0", err); end
    n_chk++;
    if (upordown !== 1'b1) begin n_err++; $display("FAIL reset_upordown got %b required 1", upordown); end
    n_chk++;
    if (num2load !== LV) begin n_err++; $display("FAIL num2load got %0d required %0d", num2load, LV); end
`ifdef QDEC_ERR_CNT_EN
    n_chk++;
    if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_err_count got %0d required 0", err_count); end
`endif
  endtask

  task automatic test_forward();
    int e0;
    e0 = ev_cnt;
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b10, 20, 0);
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL forward_pulses got %0d required 1", ev_cnt - e0); end
    n_chk++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL forward_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reverse();
    int e0;
    e0 = ev_cnt;
    drive_ab(2'b10, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL reverse_pulses got %0d required 1", ev_cnt - e0); end
    e0 = ev_cnt;
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL mixed_pulses got %0d required 0", ev_cnt - e0); end
    n_chk++;
    if (upordown !== 1'b0) begin n_err++; $display("FAIL upordown_hold got %b required 0", upordown); end
    n_chk++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL reverse_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = ev_cnt;
    @(posedge clk);
    #1 a_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 a_in = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL glitch_events got %0d required 0", ev_cnt - e0); end
  endtask

  task automatic test_illegal();
    int e0;
    e0 = ev_cnt;
    drive_ab(2'b11, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL illegal_events got %0d required 1", ev_cnt - e0); end
`ifdef QDEC_ERR_CNT_EN
    n_chk++;
    if (err_count !== 8'd1) begin n_err++; $display("FAIL err_count_1 got %0d required 1", err_count); end
`endif
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL illegal_pending got %0d required 0", exp_q.size()); end
`ifdef QDEC_ERR_CNT_EN
    n_chk++;
    if (err_count !== 8'd2) begin n_err++; $display("FAIL err_count_2 got %0d required 2", err_count); end
`endif
  endtask

  task automatic test_reset_mid();
    int e0;
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b10, 20, 0);
    e0 = ev_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    mdl_prev = 2'b00;
    mdl_acc = 0;
    mdl_ud = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL reset_mid_events got %0d required 0", ev_cnt - e0); end
    n_chk++;
    if (upordown !== 1'b1) begin n_err++; $display("FAIL reset_mid_upordown got %b required 1", upordown); end
`ifdef QDEC_ERR_CNT_EN
    n_chk++;
    if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_mid_err_count got %0d required 0", err_count); end
`endif
    // Two forward steps after reset must not complete a step: the earlier three were discarded.
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 0) begin n_err++; $display("FAIL post_reset_events got %0d required 0", ev_cnt - e0); end
  endtask

  task automatic test_index_step();
    int e0;
    e0 = ev_cnt;
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b10, 20, 0);
    drive_ab(2'b00, 20, 1);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL index_events got %0d required 1", ev_cnt - e0); end
    #1 idx_in = 1'b0;
    e0 = ev_cnt;
    drive_ab(2'b01, 20, 0);
    drive_ab(2'b11, 20, 0);
    drive_ab(2'b10, 20, 0);
    drive_ab(2'b00, 20, 0);
    @(negedge clk);
    n_chk++;
    if (ev_cnt - e0 !== 1) begin n_err++; $display("FAIL after_index_steps got %0d required 1", ev_cnt - e0); end
    n_chk++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL index_pending got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_index_step();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
